// File: rtl/testdrive_apb_regfile_completer_if.sv
// APB bus bundle between a requester (master) and a register-file completer (slave).
interface testdrive_apb_regfile_completer_if #(
  parameter int C_ADDR_BITS = 10
);
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [C_ADDR_BITS-1:0] paddr;
  logic [31:0]            pwdata;
  logic [3:0]             pstrb;
  logic [31:0]            prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/testdrive_apb_regfile_completer.sv
// APB completer over a bank of 32-bit registers with byte strobes and
// programmable wait states. Register 0 is a read-only ID word.
module testdrive_apb_regfile_completer #(
  parameter int          C_ADDR_BITS   = 10,
  parameter int          C_REG_COUNT   = 16,
  parameter logic [31:0] C_ID          = 32'h0,
  parameter int          C_WAIT_CYCLES = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  testdrive_apb_regfile_completer_if.slave apb,
  output logic [32*C_REG_COUNT-1:0]      o_reg_data,
  output logic                           o_wr_pulse,
  output logic [$clog2(C_REG_COUNT)-1:0] o_wr_index,
  output logic                           o_busy
);

  localparam int C_IDX_W = $clog2(C_REG_COUNT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             r_state;
  logic [7:0]         r_cnt;
  logic               r_pready;
  logic               r_pslverr;
  logic [31:0]        r_prdata;
  logic               r_wr_pulse;
  logic [C_IDX_W-1:0] r_wr_index;
  logic               r_busy;

  logic [31:0]            w_regs [C_REG_COUNT];
  logic [C_ADDR_BITS-3:0] w_idx;
  logic [C_IDX_W-1:0]     w_rd_idx;
  logic                   w_err;
  logic                   w_access;
  logic                   w_commit;
  logic [31:0]            w_rd_data;
  logic [31:0]            w_capture;
  logic                   w_unused_bits;

  // Word index decode; the byte offset bits carry no meaning for word registers.
  assign w_idx         = apb.paddr[C_ADDR_BITS-1:2];
  assign w_rd_idx      = w_idx[C_IDX_W-1:0];
  assign w_unused_bits = &{1'b0, apb.paddr[1:0]};
  assign w_err         = (32'(w_idx) >= 32'(C_REG_COUNT)) | (apb.pwrite & (w_idx == '0));
  assign w_access      = apb.psel & apb.penable;
  assign w_commit      = (r_state == ST_WAIT) & w_access & r_pready & apb.pwrite & ~w_err;
  assign w_rd_data     = w_err ? 32'h0 : w_regs[w_rd_idx];
  assign w_capture     = apb.pwrite ? 32'h0 : w_rd_data;

  assign w_regs[0] = C_ID;

  // Writable registers: each one commits its strobed bytes when addressed by a good write.
  for (genvar gi = 1; gi < C_REG_COUNT; gi++) begin : g_reg
    logic [31:0] r_reg;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_reg <= 32'h0;
      end else if (w_commit && (w_rd_idx == C_IDX_W'(gi))) begin
        for (int b = 0; b < 4; b++) begin
          if (apb.pstrb[b]) r_reg[8*b +: 8] <= apb.pwdata[8*b +: 8];
        end
      end
    end
    assign w_regs[gi] = r_reg;
  end

  for (genvar gi = 0; gi < C_REG_COUNT; gi++) begin : g_flat
    assign o_reg_data[32*gi +: 32] = w_regs[gi];
  end

  // Transfer FSM: setup accepted in IDLE, wait-state countdown and completion in WAIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= 32'h0;
      r_wr_pulse <= 1'b0;
      r_wr_index <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (apb.psel && !apb.penable) begin
            r_state <= ST_WAIT;
            r_busy  <= 1'b1;
            r_cnt   <= 8'(C_WAIT_CYCLES);
            if (C_WAIT_CYCLES == 0) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_capture;
            end
          end
        end
        ST_WAIT: begin
          if (!w_access) begin
            // Requester abandoned the transfer: drop back without side effects.
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end else if (r_pready) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            if (apb.pwrite && !w_err) begin
              r_wr_pulse <= 1'b1;
              r_wr_index <= w_rd_idx;
            end
          end else if (r_cnt <= 8'd1) begin
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= w_capture;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign apb.prdata  = r_prdata;
  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;
  assign o_wr_pulse  = r_wr_pulse;
  assign o_wr_index  = r_wr_index;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_testdrive_apb_regfile_completer.sv
// Bench for the APB register-file completer: three instances with 0, 3 and 2
// wait states share one requester; a word-array model predicts every response.
module tb_testdrive_apb_regfile_completer;
  localparam int AW = 10;
  localparam int NR = 16;
  localparam int ND = 3;

  function automatic int wait_of(int k);
    case (k)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] id_of(int k);
    return 32'h1D00_0000 + 32'(k);
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        psel_bus = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;

  logic [31:0]       o_prdata [ND];
  logic              o_pready [ND];
  logic              o_pslverr[ND];
  logic [32*NR-1:0]  o_regs   [ND];
  logic              o_pulse  [ND];
  logic [3:0]        o_widx   [ND];
  logic              o_busy   [ND];

  testdrive_apb_regfile_completer_if #(.C_ADDR_BITS(AW)) bus [ND] ();

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    assign bus[gi].psel    = psel_bus && (sel == gi);
    assign bus[gi].penable = penable;
    assign bus[gi].pwrite  = pwrite;
    assign bus[gi].paddr   = paddr;
    assign bus[gi].pwdata  = pwdata;
    assign bus[gi].pstrb   = pstrb;
    assign o_prdata[gi]    = bus[gi].prdata;
    assign o_pready[gi]    = bus[gi].pready;
    assign o_pslverr[gi]   = bus[gi].pslverr;

    testdrive_apb_regfile_completer #(
      .C_ADDR_BITS(AW), .C_REG_COUNT(NR),
      .C_ID(id_of(gi)), .C_WAIT_CYCLES(wait_of(gi))
    ) u_dut (
      .i_clk(clk), .i_rst(rst), .apb(bus[gi]),
      .o_reg_data(o_regs[gi]), .o_wr_pulse(o_pulse[gi]),
      .o_wr_index(o_widx[gi]), .o_busy(o_busy[gi])
    );
  end

  // Reference model: plain register words per instance.
  logic [31:0] mregs [ND][NR];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(int k, int i);
    return (i == 0) ? id_of(k) : mregs[k][i];
  endfunction

  task automatic clear_model();
    for (int k = 0; k < ND; k++)
      for (int i = 0; i < NR; i++) mregs[k][i] = 32'h0;
  endtask

  task automatic check_regs(input int k);
    for (int i = 0; i < NR; i++)
      chk($sformatf("reg_data%0d[%0d]", k, i), o_regs[k][32*i +: 32], model_word(k, i));
  endtask

  task automatic idle(input int k, input int cycles);
    psel_bus = 1'b0; penable = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      chk("idle_pulse", o_pulse[k], 0);
      chk("idle_pready", o_pready[k], 0);
      chk("idle_busy", o_busy[k], 0);
    end
  endtask

  // One full transfer starting at a negedge; leaves the bus idle at the negedge after completion.
  task automatic xfer(input int k, input bit wr, input logic [AW-1:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    int idx, n;
    bit err, rdy;
    logic [31:0] exp_rd;
    idx = int'(addr[AW-1:2]);
    err = (idx >= NR) || (wr && idx == 0);
    exp_rd = (wr || err) ? 32'h0 : model_word(k, idx);
    sel = k; psel_bus = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    n = 0; rdy = 1'b0;
    while (!rdy && n < 300) begin
      @(negedge clk);
      n++;
      penable = 1'b1;
      chk("busy", o_busy[k], 1);
      rdy = o_pready[k];
      if (!rdy) chk("pslverr_lo", o_pslverr[k], 0);
    end
    chk("latency", n, wait_of(k) + 1);
    chk("prdata", o_prdata[k], exp_rd);
    chk("pslverr", o_pslverr[k], err);
    @(negedge clk);
    psel_bus = 1'b0; penable = 1'b0;
    if (wr && !err)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mregs[k][idx][8*b +: 8] = data[8*b +: 8];
    chk("wr_pulse", o_pulse[k], wr && !err);
    if (wr && !err) chk("wr_index", o_widx[k], idx[3:0]);
    chk("pready_clr", o_pready[k], 0);
    chk("pslverr_clr", o_pslverr[k], 0);
    chk("busy_clr", o_busy[k], 0);
    chk("prdata_hold", o_prdata[k], exp_rd);
    check_regs(k);
    $display("xfer dut%0d %s addr=%h wdata=%h strb=%h prdata=%h slverr=%0d cycles=%0d",
             k, wr ? "WR" : "RD", addr, data, strb, o_prdata[k], err, n);
  endtask

  // Transfer abandoned in access cycle d by dropping PSEL (or PENABLE).
  task automatic xabort(input int k, input bit wr, input logic [AW-1:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input int d, input bit drop_en);
    sel = k; psel_bus = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    for (int n = 1; n <= d; n++) begin
      @(negedge clk);
      if (n < d) penable = 1'b1;
      else if (drop_en) penable = 1'b0;
      else psel_bus = 1'b0;
    end
    @(negedge clk);
    psel_bus = 1'b0; penable = 1'b0;
    chk("abort_pready", o_pready[k], 0);
    chk("abort_pslverr", o_pslverr[k], 0);
    chk("abort_busy", o_busy[k], 0);
    chk("abort_pulse", o_pulse[k], 0);
    check_regs(k);
    $display("abort dut%0d %s addr=%h at access cycle %0d", k, wr ? "WR" : "RD", addr, d);
  endtask

  // Access phase without a setup phase must be ignored.
  task automatic stray(input int k);
    sel = k; psel_bus = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 10'h004;
    @(negedge clk);
    psel_bus = 1'b0; penable = 1'b0;
    chk("stray_pready", o_pready[k], 0);
    chk("stray_busy", o_busy[k], 0);
    $display("stray access dut%0d ignored check", k);
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < ND; k++) begin
      chk("rst_prdata", o_prdata[k], 0);
      chk("rst_pready", o_pready[k], 0);
      chk("rst_pslverr", o_pslverr[k], 0);
      chk("rst_pulse", o_pulse[k], 0);
      chk("rst_widx", o_widx[k], 0);
      chk("rst_busy", o_busy[k], 0);
      check_regs(k);
    end

    // Zero-wait write then read back.
    xfer(0, 1'b1, 10'h004, 32'hDEADBEEF, 4'hF);
    chk("reg1_const", o_regs[0][63:32], 32'hDEADBEEF);
    xfer(0, 1'b0, 10'h004, 32'h0, 4'h0);
    // Three wait states, ID read.
    xfer(1, 1'b0, 10'h000, 32'h0, 4'h0);
    // Partial strobes.
    xfer(0, 1'b1, 10'h008, 32'hAABBCCDD, 4'hF);
    xfer(0, 1'b1, 10'h008, 32'h11223344, 4'b0101);
    chk("strb_merge", o_regs[0][95:64], 32'hAA22CC44);
    // Error responses.
    xfer(0, 1'b0, 10'(4*NR), 32'h0, 4'h0);
    xfer(0, 1'b1, 10'(4*NR), 32'h12345678, 4'hF);
    xfer(0, 1'b1, 10'h000, 32'h12345678, 4'hF);
    xfer(1, 1'b1, 10'h3FC, 32'hCAFEF00D, 4'hF);

    // Reset in the 2nd access cycle of a write to reg 3.
    sel = 2; psel_bus = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 10'h00C; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; psel_bus = 1'b0; penable = 1'b0;
    clear_model();
    chk("rstmid_pready", o_pready[2], 0);
    chk("rstmid_reg3", o_regs[2][127:96], 32'h0);
    chk("rstmid_busy", o_busy[2], 0);
    for (int k = 0; k < ND; k++) check_regs(k);
    xfer(2, 1'b1, 10'h00C, 32'h0BADF00D, 4'hF);

    // Abort mid-WAIT, then back-to-back write and read.
    xabort(2, 1'b1, 10'h010, 32'h77777777, 4'hF, 2, 1'b0);
    xfer(2, 1'b1, 10'h014, 32'h13579BDF, 4'hF);
    xfer(2, 1'b0, 10'h014, 32'h0, 4'h0);
    stray(0);

    // Randomized traffic.
    for (int it = 0; it < 150; it++) begin
      int k, idx, mode;
      logic [AW-1:0] addr;
      k = $urandom_range(0, ND-1);
      idx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, NR+2);
      addr = AW'({idx[7:0], 2'(($urandom_range(0, 3)))});
      mode = $urandom_range(0, 19);
      if (mode == 0)
        xabort(k, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(1, wait_of(k) + 1), 1'($urandom_range(0, 1)));
      else if (mode == 1)
        stray(k);
      else
        xfer(k, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) != 0) idle(k, $urandom_range(1, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
